// File: rtl/disk_ii_pkg.sv
// disk_ii_pkg: shared soft-switch offsets, types and the stepper direction rule
// for the Disk II controller.
package disk_ii_pkg;
  localparam logic [3:0] PH0   = 4'h0;
  localparam logic [3:0] PH1   = 4'h2;
  localparam logic [3:0] PH2   = 4'h4;
  localparam logic [3:0] PH3   = 4'h6;
  localparam logic [3:0] MOTOR = 4'h8;
  localparam logic [3:0] SEL   = 4'hA;
  localparam logic [3:0] Q6    = 4'hC;
  localparam logic [3:0] Q7    = 4'hE;
  localparam int HT_MAX_DEF = 68;
  localparam int HT_W_DEF   = 7;
  typedef logic [HT_W_DEF-1:0] ht_t;
  typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DN} step_dir_e;
  typedef enum logic [1:0] {M_OFF, M_ON, M_SPIN} motor_e;
  function automatic logic sw_hit(input logic [3:0] a, input logic [3:0] off);
    return a[3:1] == off[3:1];
  endfunction
  // The magnet ahead of or behind the current position pulls the head one half-track.
  function automatic step_dir_e step_dir(input logic [3:0] ph, input logic [1:0] p);
    logic [1:0] u, d;
    u = p + 2'd1;
    d = p + 2'd3;
    return (ph[u] & ~ph[d]) ? STEP_UP : (ph[d] & ~ph[u]) ? STEP_DN : STEP_HOLD;
  endfunction
endpackage

// File: rtl/disk_ii_head_stepper.sv
// disk_ii_head_stepper: half-track position of one drive, stepped by the phase
// magnets, saturating at 0 and HT_MAX.
module disk_ii_head_stepper
  import disk_ii_pkg::*;
#(
  parameter int HT_MAX = HT_MAX_DEF,
  parameter int HT_W   = HT_W_DEF
) (
  input  logic            clk_logic,
  input  logic            system_reset_n,
  input  logic [3:0]      phases_i,
  input  logic            step_en_i,
  output logic [HT_W-1:0] ht_o
);
  logic [HT_W-1:0] ht_q, ht_d;
  step_dir_e dir;
  always_comb begin
    dir = step_dir(phases_i, ht_q[1:0]);
    ht_d = ht_q;
    if (step_en_i && dir == STEP_UP && ht_q < HT_W'(HT_MAX)) ht_d = ht_q + HT_W'(1);
    if (step_en_i && dir == STEP_DN && ht_q != '0) ht_d = ht_q - HT_W'(1);
  end
  always_ff @(posedge clk_logic or negedge system_reset_n)
    if (!system_reset_n) ht_q <= '0;
    else ht_q <= ht_d;
  assign ht_o = ht_q;
endmodule

// File: rtl/disk_ii_ctrl_n.sv
// disk_ii_ctrl_n: Disk II soft-switch decode, motor spindown, per-drive head
// tracking and read/sense/write data latch for up to four drives.
module disk_ii_ctrl_n
  import disk_ii_pkg::*;
#(
  parameter int NUM_DRIVES      = 2,
  parameter int SPINDOWN_CYCLES = 14000000,
  parameter int HT_MAX          = HT_MAX_DEF,
  parameter int HT_W            = HT_W_DEF,
  localparam int SW = NUM_DRIVES > 1 ? $clog2(NUM_DRIVES) : 1,
  localparam int CW = $clog2(SPINDOWN_CYCLES + 1)
) (
  input  logic                  clk_logic,
  input  logic                  system_reset_n,
  input  logic                  dev_sel_stb_i,
  input  logic [3:0]            addr_i,
  input  logic                  rw_n_i,
  input  logic [7:0]            data_i,
  input  logic                  bank_i,
  input  logic                  nib_valid_i,
  input  logic [7:0]            nib_i,
  input  logic [NUM_DRIVES-1:0] wp_i,
  output logic [7:0]            data_o,
  output logic                  rd_en_o,
  output logic [SW-1:0]         drive_sel_o,
  output logic [NUM_DRIVES-1:0] motor_on_o,
  output logic [HT_W-1:0]       half_track_o,
  output logic                  wr_valid_o,
  output logic [7:0]            wr_nib_o,
  output logic                  write_mode_o
);
  logic [3:0]    phase_q, phase_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          q6_q, q6_d, q7_q, q7_d;
  logic [7:0]    latch_q, latch_d;
  logic          step_en_q, wr_valid_q;
  logic [7:0]    wr_nib_q;
  motor_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sw_ph, sw_mot, motor, rd_lat, wr_go;
  logic [1:0]    sel_idx;
  logic [HT_W-1:0] ht [NUM_DRIVES];

  assign sw_ph   = dev_sel_stb_i & ~addr_i[3];
  assign sw_mot  = dev_sel_stb_i & sw_hit(addr_i, MOTOR);
  assign sel_idx = {bank_i & (NUM_DRIVES > 2), addr_i[0]};
  assign motor   = st_q != M_OFF;

  // q6_d/q7_d double as the effective Q6/Q7 seen by the access in flight.
  always_comb begin
    phase_d = phase_q;
    if (sw_ph) phase_d[addr_i[2:1]] = addr_i[0];
    sel_d  = (dev_sel_stb_i && sw_hit(addr_i, SEL) && 32'(sel_idx) < NUM_DRIVES) ? SW'(sel_idx) : sel_q;
    q6_d   = (dev_sel_stb_i && sw_hit(addr_i, Q6)) ? addr_i[0] : q6_q;
    q7_d   = (dev_sel_stb_i && sw_hit(addr_i, Q7)) ? addr_i[0] : q7_q;
    rd_lat = dev_sel_stb_i & ~q6_d & ~q7_d;
    latch_d = nib_valid_i ? nib_i : rd_lat ? {1'b0, latch_q[6:0]} : latch_q;
    wr_go  = dev_sel_stb_i & ~rw_n_i & addr_i[0] & q6_d & q7_d & motor & ~wp_i[sel_q];
  end

  always_ff @(posedge clk_logic or negedge system_reset_n)
    if (!system_reset_n) begin
      phase_q    <= '0;
      sel_q      <= '0;
      q6_q       <= 1'b0;
      q7_q       <= 1'b0;
      latch_q    <= '0;
      step_en_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_nib_q   <= '0;
    end else begin
      phase_q    <= phase_d;
      sel_q      <= sel_d;
      q6_q       <= q6_d;
      q7_q       <= q7_d;
      latch_q    <= latch_d;
      step_en_q  <= sw_ph & motor;
      wr_valid_q <= wr_go;
      wr_nib_q   <= wr_go ? data_i : wr_nib_q;
    end

  always_ff @(posedge clk_logic or negedge system_reset_n)
    if (!system_reset_n) begin
      st_q  <= M_OFF;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (sw_mot && addr_i[0]) begin
      st_d  = M_ON;
      cnt_d = '0;
    end else if (sw_mot && st_q == M_ON) begin
      st_d  = M_SPIN;
      cnt_d = CW'(SPINDOWN_CYCLES - 1);
    end else if (st_q == M_SPIN) begin
      st_d  = cnt_q == '0 ? M_OFF : M_SPIN;
      cnt_d = cnt_q == '0 ? '0 : cnt_q - CW'(1);
    end
  end

  always_comb begin
    motor_on_o = motor ? NUM_DRIVES'(1) << sel_q : '0;
    data_o     = !dev_sel_stb_i ? 8'h00 : rd_lat ? latch_q : (q6_d & ~q7_d) ? {wp_i[sel_q], 7'b0} : 8'h00;
  end

  for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_drv
    disk_ii_head_stepper #(.HT_MAX(HT_MAX), .HT_W(HT_W)) u_step (
      .clk_logic      (clk_logic),
      .system_reset_n (system_reset_n),
      .phases_i       (phase_q),
      .step_en_i      (step_en_q && sel_q == SW'(g)),
      .ht_o           (ht[g])
    );
  end

  assign rd_en_o      = dev_sel_stb_i & rw_n_i;
  assign drive_sel_o  = sel_q;
  assign half_track_o = ht[sel_q];
  assign wr_valid_o   = wr_valid_q;
  assign wr_nib_o     = wr_nib_q;
  assign write_mode_o = q7_q;
endmodule
